blitstop_multi: RTL and testbench
=================================

# blitstop_multi

Multi-channel blitter stop controller: the parametrised successor of the single-channel blitter collision-stop block. It watches NCH independent collision sources, each being a data-write cycle whose write is inhibited by the comparator. On a rising collision on any enabled channel it halts the blitter and records which channels collided and how often. The GPU then either resumes the blitter or aborts it; an abort drives a timed reset pulse. The block sits between the GPU register bus and the blitter core.

## Interface
Parameters:
- NCH, 4: number of collision channels, legal range 1..8.
- CNTW, 8: width of the saturating collision counter, legal range 1..8.
- ABORT_LEN, 4: length of the abort reset pulse in ce cycles, legal range 1..255.
- CHW, max(1, $clog2(NCH)) (derived): width of coll_ch.

Ports:
- sys_clk  in  1  system clock; reset resetl, synchronous, active-low; clock sys_clk.
- resetl  in  1  synchronous active-low reset; acts regardless of ce.
- ce  in  1  blitter clock-phase enable; all non-reset state updates occur only on sys_clk edges where ce=1.
- gpu_din  in  32  GPU write data.
- stopld  in  1  control-register write strobe; qualified by ce.
- statrd  in  1  status-register read strobe.
- nowrite  in  NCH  per-channel write-inhibit (comparator) flag.
- dwrite  in  NCH  per-channel data-write cycle flag.
- xreset_n  in  1  external active-low reset, passed through to reset_n.
- stat_out  out  32  status word (combinational from registers).
- stat_oe  out  1  equals statrd (combinational).
- stopped  out  1  blitter halted.
- coll_ch  out  CHW  lowest-index channel in the latched collision mask.
- irq  out  1  one-sys_clk pulse on entry to STOPPED.
- reset_n  out  1  xreset_n & ~drv_reset.

## Operation
- Control write (stopld & ce) uses these gpu_din bits:
  - [0] resume.
  - [1] abort.
  - [2] stopen: global enable, loaded on every write.
  - [3] clear the collision counter.
  - [8+NCH-1:8] chen: per-channel enable mask, loaded on every write.
- Per channel i: collidea[i] = nowrite[i] & dwrite[i] & chen[i] & stopen.
  - collideb[i] is a ce-qualified register holding the previous collidea[i].
  - rise[i] = collidea[i] & ~collideb[i].
  - collideb updates in every state.
- State machine with states IDLE, STOPPED and ABORT; the reset state is IDLE.
- IDLE: if |rise, then in the same ce cycle:
  - go to STOPPED;
  - latch coll_mask <= rise;
  - coll_ch <= index of the lowest set bit of rise;
  - increment cnt, saturating at 2^CNTW-1;
  - assert irq for the next sys_clk cycle only.
- STOPPED: further rises are ignored (not counted, mask unchanged).
  - A control write with bit1=1 goes to ABORT and loads abcnt <= ABORT_LEN.
  - Otherwise a control write with bit0=1 goes to IDLE.
  - If bit1 and bit0 are both set, abort wins.
- ABORT: drv_reset=1.
  - abcnt decrements on each ce cycle.
  - When abcnt==1 on a ce cycle, go to IDLE and clear drv_reset.
  - This gives exactly ABORT_LEN ce cycles of drv_reset.
  - Collisions are ignored.
- Resume and abort bits have no effect outside STOPPED. stopen and chen load in every state.
- Counter clear versus increment in the same ce cycle: the clear wins and cnt ends at 0.
- coll_mask and coll_ch hold their values until the next stop event.
- stopped = (state==STOPPED). drv_reset = (state==ABORT). Both are registered.
- stat_out layout, unused bits 0:
  - [0] drv_reset;
  - [1] stopped, at the same bit position as the legacy stop status;
  - [2] stopen;
  - [7:4] coll_ch, zero-extended;
  - [15:8] chen, zero-extended;
  - [23:16] coll_mask, zero-extended;
  - [31:24] cnt, zero-extended.

## Timing
- Reset (resetl=0 on any sys_clk edge) leaves:
  - state IDLE;
  - stopped=0, drv_reset=0, irq=0, coll_ch=0, coll_mask=0, cnt=0, stopen=0, chen=0, collideb=0, abcnt=0;
  - reset_n = xreset_n.
- Reset mid-ABORT ends the pulse immediately on the next edge.
- Collision latency: rise at ce edge k gives stopped=1 and irq=1 in cycle k+1. irq falls at k+2 regardless of ce.
- A held collidea stops the blitter only once; a new stop needs collidea to go low and then high again, sampled on ce cycles.
- Resume written at ce edge k gives stopped=0 in cycle k+1. A rise sampled at edge k+1 may stop the blitter again.
- Abort written at ce edge k gives reset_n=0 from cycle k+1 through the ABORT_LEN-th subsequent ce edge.
- Edges with ce=0 change nothing except through resetl. irq clearing is the only exception.
- stat_out and stat_oe are combinational and carry zero added latency.

## Test plan
- Reset, then write 0x0000_0F04 (stopen, chen=0xF), then pulse nowrite[2]&dwrite[2] for one ce cycle -> stopped=1 next cycle, irq high for one cycle, coll_ch=2, stat_out=0x0104_0F26.
- While STOPPED, raise channels 0 and 3 -> no change. Write 0x0000_0F05 (resume) -> stopped=0. Raise channels 1 and 3 together -> coll_ch=1, coll_mask=0x0A, cnt=2.
- Write 0x0000_0F06 in STOPPED with ABORT_LEN=4 and ce toggling every other cycle -> reset_n low for exactly 4 ce edges, then IDLE with stopped=0.
- Write resume|abort (0x0000_0F07) in STOPPED -> ABORT entered and no resume.
- With CNTW=2, cause 5 stop/resume cycles -> cnt saturates at 3. Write bit3 in the same ce cycle as a rise -> cnt=0.
- Assert resetl=0 mid-ABORT -> the next cycle shows reset_n=xreset_n, stopped=0 and stat_out=0. Hold collidea high continuously -> only one stop event.

Source files
------------

// File: rtl/blitstop_multi.sv
`default_nettype none
// -----------------------------------------------------------------------------
// blitstop_multi : multi-channel blitter collision-stop controller with
//                  resume / timed-abort handling and a GPU status word.
// Revision 1.0
// -----------------------------------------------------------------------------
module blitstop_multi #(
  parameter int NCH       = 4,
  parameter int CNTW      = 8,
  parameter int ABORT_LEN = 4,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            sys_clk,
  input  logic            resetl,
  input  logic            ce,
  input  logic [31:0]     gpu_din,
  input  logic            stopld,
  input  logic            statrd,
  input  logic [NCH-1:0]  nowrite,
  input  logic [NCH-1:0]  dwrite,
  input  logic            xreset_n,
  output logic [31:0]     stat_out,
  output logic            stat_oe,
  output logic            stopped,
  output logic [CHW-1:0]  coll_ch,
  output logic            irq,
  output logic            reset_n
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STOPPED = 2'd1,
    ABORT   = 2'd2
  } state_t;

  localparam logic [7:0]      ABORT_INIT = 8'(ABORT_LEN);
  localparam logic [CNTW-1:0] CNT_MAX    = '1;

  state_t          state_q, state_d;
  logic [NCH-1:0]  collideb_q, collideb_d;
  logic            stopen_q, stopen_d;
  logic [NCH-1:0]  chen_q, chen_d;
  logic [NCH-1:0]  coll_mask_q, coll_mask_d;
  logic [CHW-1:0]  coll_ch_q, coll_ch_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [7:0]      abcnt_q, abcnt_d;
  logic            irq_q, irq_d;

  logic [NCH-1:0]  collidea;
  logic [NCH-1:0]  rise;
  logic [CHW-1:0]  rise_idx;
  logic            ctl_wr;
  logic            drv_reset;
  logic            unused_din;

  assign unused_din = ^{gpu_din[31:8+NCH], gpu_din[7:4]};

  always_comb begin
    collidea = nowrite & dwrite & chen_q & {NCH{stopen_q}};
    rise     = collidea & ~collideb_q;
    ctl_wr   = stopld & ce;
    rise_idx = '0;
    // Descending scan so the lowest set bit is the one left standing.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = CHW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    collideb_d  = collideb_q;
    stopen_d    = stopen_q;
    chen_d      = chen_q;
    coll_mask_d = coll_mask_q;
    coll_ch_d   = coll_ch_q;
    cnt_d       = cnt_q;
    abcnt_d     = abcnt_q;
    irq_d       = 1'b0;
    if (ce) begin
      collideb_d = collidea;
      case (state_q)
        IDLE: begin
          if (|rise) begin
            state_d     = STOPPED;
            coll_mask_d = rise;
            coll_ch_d   = rise_idx;
            irq_d       = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
        end
        STOPPED: begin
          if (ctl_wr && gpu_din[1]) begin
            state_d = ABORT;
            abcnt_d = ABORT_INIT;
          end else if (ctl_wr && gpu_din[0]) begin
            state_d = IDLE;
          end
        end
        ABORT: begin
          abcnt_d = abcnt_q - 8'd1;
          if (abcnt_q == 8'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (ctl_wr) begin
        stopen_d = gpu_din[2];
        chen_d   = gpu_din[8 +: NCH];
        // A clear in the same cycle as a stop event overrides the increment.
        if (gpu_din[3]) cnt_d = '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state_q     <= IDLE;
      collideb_q  <= '0;
      stopen_q    <= 1'b0;
      chen_q      <= '0;
      coll_mask_q <= '0;
      coll_ch_q   <= '0;
      cnt_q       <= '0;
      abcnt_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      collideb_q  <= collideb_d;
      stopen_q    <= stopen_d;
      chen_q      <= chen_d;
      coll_mask_q <= coll_mask_d;
      coll_ch_q   <= coll_ch_d;
      cnt_q       <= cnt_d;
      abcnt_q     <= abcnt_d;
      irq_q       <= irq_d;
    end
  end

  assign stopped   = (state_q == STOPPED);
  assign drv_reset = (state_q == ABORT);
  assign irq       = irq_q;
  assign coll_ch   = coll_ch_q;
  assign reset_n   = xreset_n & ~drv_reset;
  assign stat_oe   = statrd;

  always_comb begin
    stat_out            = '0;
    stat_out[0]         = drv_reset;
    stat_out[1]         = stopped;
    stat_out[2]         = stopen_q;
    stat_out[4 +: CHW]  = coll_ch_q;
    stat_out[8 +: NCH]  = chen_q;
    stat_out[16 +: NCH] = coll_mask_q;
    stat_out[24 +: CNTW] = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_blitstop_multi.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_blitstop_multi : scenario and randomized checks of blitstop_multi against
//                     a behavioural model.
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_blitstop_multi;

  localparam int NCH       = 4;
  localparam int CNTW      = 2;
  localparam int ABORT_LEN = 4;
  localparam int CHW       = 2;
  localparam int CMAX      = (1 << CNTW) - 1;

  logic           sys_clk = 1'b0;
  logic           resetl = 1'b0;
  logic           ce = 1'b0;
  logic [31:0]    gpu_din = '0;
  logic           stopld = 1'b0;
  logic           statrd = 1'b0;
  logic [NCH-1:0] nowrite = '0;
  logic [NCH-1:0] dwrite = '0;
  logic           xreset_n = 1'b1;
  logic [31:0]    stat_out;
  logic           stat_oe;
  logic           stopped;
  logic [CHW-1:0] coll_ch;
  logic           irq;
  logic           reset_n;

  int checks = 0;
  int failures = 0;

  // Behavioural model: abort tracked as "ce edges of reset pulse remaining".
  int       m_stopped, m_abort_left, m_stopen, m_chen, m_mask, m_ch, m_cnt, m_irq;
  bit [3:0] m_prev;

  blitstop_multi #(.NCH(NCH), .CNTW(CNTW), .ABORT_LEN(ABORT_LEN)) dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .ce      (ce),
    .gpu_din (gpu_din),
    .stopld  (stopld),
    .statrd  (statrd),
    .nowrite (nowrite),
    .dwrite  (dwrite),
    .xreset_n(xreset_n),
    .stat_out(stat_out),
    .stat_oe (stat_oe),
    .stopped (stopped),
    .coll_ch (coll_ch),
    .irq     (irq),
    .reset_n (reset_n)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [31:0] exp_stat();
    int v;
    v = (m_cnt << 24) | (m_mask << 16) | (m_chen << 8) | (m_ch << 4) |
        (m_stopen << 2) | (m_stopped << 1) | ((m_abort_left > 0) ? 1 : 0);
    return 32'(v);
  endfunction

  function automatic logic exp_reset_n();
    return xreset_n & (m_abort_left == 0);
  endfunction

  task automatic model_reset();
    m_stopped = 0; m_abort_left = 0; m_stopen = 0; m_chen = 0;
    m_mask = 0; m_ch = 0; m_cnt = 0; m_irq = 0; m_prev = '0;
  endtask

  task automatic model_edge();
    bit [3:0] coll, rise;
    int nxt_irq;
    if (!resetl) begin
      model_reset();
      return;
    end
    coll = nowrite & dwrite & ((m_stopen != 0) ? 4'(m_chen) : 4'b0);
    rise = coll & ~m_prev;
    nxt_irq = 0;
    if (ce) begin
      m_prev = coll;
      if (m_abort_left > 0) begin
        m_abort_left--;
      end else if (m_stopped != 0) begin
        if (stopld && gpu_din[1]) begin
          m_stopped = 0;
          m_abort_left = ABORT_LEN;
        end else if (stopld && gpu_din[0]) begin
          m_stopped = 0;
        end
      end else if (rise != 0) begin
        m_stopped = 1;
        m_mask = int'(rise);
        for (int i = 3; i >= 0; i--) if (rise[i]) m_ch = i;
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        nxt_irq = 1;
      end
      if (stopld) begin
        if (gpu_din[3]) m_cnt = 0;
        m_stopen = int'(gpu_din[2]);
        m_chen = int'(gpu_din[11:8]);
      end
    end
    m_irq = nxt_irq;
  endtask

  task automatic cyc(input logic c, input logic ld, input logic [31:0] din,
                     input logic [3:0] nw, input logic [3:0] dw);
    ce = c; stopld = ld; gpu_din = din; nowrite = nw; dwrite = dw;
    @(posedge sys_clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    resetl = 1'b0; xreset_n = 1'b1; statrd = 1'b0;
    cyc(1, 1, 32'hFFFF_FFFF, 4'hF, 4'hF);
    cyc(0, 0, 0, 0, 0);
    checks++; if (stat_out !== 32'h0) begin failures++; $display("FAIL reset_stat got=%h exp=%h", stat_out, 32'h0); end
    checks++; if (stopped !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", stopped, irq); end
    checks++; if (coll_ch !== 2'd0) begin failures++; $display("FAIL reset_coll_ch got=%0d exp=0", coll_ch); end
    checks++; if (reset_n !== 1'b1) begin failures++; $display("FAIL reset_reset_n got=%b exp=1", reset_n); end
    checks++; if (stat_oe !== 1'b0) begin failures++; $display("FAIL reset_stat_oe got=%b exp=0", stat_oe); end
    statrd = 1'b1; #1;
    checks++; if (stat_oe !== 1'b1) begin failures++; $display("FAIL stat_oe_follow got=%b exp=1", stat_oe); end
    statrd = 1'b0;
    resetl = 1'b1;
  endtask

  task automatic test_stop();
    cyc(1, 1, 32'h0000_0F04, 0, 0);
    cyc(1, 0, 0, 4'b0100, 4'b0100);
    checks++; if (stopped !== 1'b1 || irq !== 1'b1) begin failures++; $display("FAIL stop_entry got=%b%b exp=11", stopped, irq); end
    checks++; if (coll_ch !== 2'd2) begin failures++; $display("FAIL stop_coll_ch got=%0d exp=2", coll_ch); end
    checks++; if (stat_out !== 32'h0104_0F26) begin failures++; $display("FAIL stop_stat got=%h exp=%h", stat_out, 32'h0104_0F26); end
    cyc(1, 0, 0, 0, 0);
    checks++; if (irq !== 1'b0 || stopped !== 1'b1) begin failures++; $display("FAIL stop_irq_pulse got=%b%b exp=01", irq, stopped); end
  endtask

  task automatic test_stopped_ignore();
    cyc(1, 0, 0, 4'b1001, 4'b1001);
    checks++; if (stat_out !== 32'h0104_0F26 || irq !== 1'b0) begin failures++; $display("FAIL ignore_stat got=%h irq=%b exp=%h irq=0", stat_out, irq, 32'h0104_0F26); end
    cyc(1, 1, 32'h0000_0F05, 0, 0);
    checks++; if (stopped !== 1'b0) begin failures++; $display("FAIL resume got=%b exp=0", stopped); end
    cyc(1, 0, 0, 4'b1010, 4'b1010);
    checks++; if (coll_ch !== 2'd1 || stat_out !== 32'h020A_0F16) begin failures++; $display("FAIL second_stop got=%h ch=%0d exp=%h ch=1", stat_out, coll_ch, 32'h020A_0F16); end
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    int ce_edges;
    logic was_low;
    cyc(1, 1, 32'h0000_0F06, 0, 0);
    checks++; if (reset_n !== 1'b0 || stopped !== 1'b0 || stat_out[0] !== 1'b1) begin failures++; $display("FAIL abort_entry got=rn%b st%b dr%b exp=rn0 st0 dr1", reset_n, stopped, stat_out[0]); end
    ce_edges = 0;
    for (int i = 0; i < 16; i++) begin
      was_low = ~reset_n;
      cyc(logic'(i % 2), 0, 0, 4'hF, 4'hF);
      if (was_low && (i % 2) == 1) ce_edges++;
      checks++; if (reset_n !== exp_reset_n() || stopped !== 1'b0) begin failures++; $display("FAIL abort_step%0d got=rn%b st%b exp=rn%b st0", i, reset_n, stopped, exp_reset_n()); end
    end
    checks++; if (ce_edges != ABORT_LEN) begin failures++; $display("FAIL abort_len got=%0d exp=%0d", ce_edges, ABORT_LEN); end
    cyc(1, 0, 0, 0, 0);
    checks++; if (reset_n !== 1'b1 || stopped !== 1'b0 || stat_out !== exp_stat()) begin failures++; $display("FAIL abort_exit got=%h exp=%h", stat_out, exp_stat()); end
  endtask

  task automatic test_resume_abort();
    cyc(1, 0, 0, 4'b0001, 4'b0001);
    checks++; if (stopped !== 1'b1 || coll_ch !== 2'd0) begin failures++; $display("FAIL ra_stop got=%b ch=%0d exp=1 ch=0", stopped, coll_ch); end
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 32'h0000_0F07, 0, 0);
    checks++; if (stat_out[0] !== 1'b1 || stopped !== 1'b0 || stat_out !== exp_stat()) begin failures++; $display("FAIL resume_abort got=%h exp=%h", stat_out, exp_stat()); end
    for (int i = 0; i < ABORT_LEN; i++) cyc(1, 0, 0, 0, 0);
    checks++; if (reset_n !== 1'b1 || stopped !== 1'b0) begin failures++; $display("FAIL ra_done got=rn%b st%b exp=rn1 st0", reset_n, stopped); end
  endtask

  task automatic test_saturate();
    logic [3:0] k;
    int exp_cnt;
    cyc(1, 1, 32'h0000_0F0C, 0, 0);
    for (int n = 1; n <= 5; n++) begin
      k = 4'(1 << $urandom_range(0, 3));
      cyc(1, 0, 0, k, k);
      exp_cnt = (n < CMAX) ? n : CMAX;
      checks++; if (stat_out[31:24] !== 8'(exp_cnt) || stopped !== 1'b1) begin failures++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", n, stat_out[31:24], exp_cnt); end
      cyc(1, 1, 32'h0000_0F05, 0, 0);
    end
    cyc(1, 1, 32'h0000_0F0C, 4'b0010, 4'b0010);
    checks++; if (stopped !== 1'b1 || irq !== 1'b1 || stat_out[31:24] !== 8'd0) begin failures++; $display("FAIL clear_vs_inc got=st%b irq%b cnt%0d exp=st1 irq1 cnt0", stopped, irq, stat_out[31:24]); end
    cyc(1, 1, 32'h0000_0F05, 0, 0);
  endtask

  task automatic test_reset_mid_abort();
    cyc(1, 0, 0, 4'b1000, 4'b1000);
    cyc(1, 1, 32'h0000_0F06, 0, 0);
    cyc(1, 0, 0, 0, 0);
    checks++; if (reset_n !== 1'b0) begin failures++; $display("FAIL mid_abort_pre got=%b exp=0", reset_n); end
    xreset_n = 1'b1; resetl = 1'b0;
    cyc(1, 0, 0, 0, 0);
    checks++; if (reset_n !== 1'b1 || stopped !== 1'b0 || stat_out !== 32'h0) begin failures++; $display("FAIL mid_abort_reset got=rn%b st%b stat=%h exp=rn1 st0 stat=0", reset_n, stopped, stat_out); end
    xreset_n = 1'b0; #1;
    checks++; if (reset_n !== 1'b0) begin failures++; $display("FAIL xreset_pass got=%b exp=0", reset_n); end
    xreset_n = 1'b1;
    resetl = 1'b1;
  endtask

  task automatic test_held();
    int irqs;
    cyc(1, 1, 32'h0000_0F04, 0, 0);
    irqs = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) cyc(1, 1, 32'h0000_0F05, 4'b0010, 4'b0010);
      else        cyc(1, 0, 0, 4'b0010, 4'b0010);
      if (irq === 1'b1) irqs++;
    end
    checks++; if (irqs != 1 || stopped !== 1'b0) begin failures++; $display("FAIL held_once got=irqs%0d st%b exp=irqs1 st0", irqs, stopped); end
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 4'b0010, 4'b0010);
    checks++; if (stopped !== 1'b1 || coll_ch !== 2'd1) begin failures++; $display("FAIL held_rearm got=st%b ch%0d exp=st1 ch1", stopped, coll_ch); end
    cyc(1, 1, 32'h0000_0F05, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] din;
    for (int i = 0; i < 400; i++) begin
      resetl   = ($urandom_range(0, 63) != 0);
      xreset_n = ($urandom_range(0, 15) != 0);
      statrd   = logic'($urandom_range(0, 1));
      din      = $urandom;
      din[2]   = ($urandom_range(0, 7) != 0);
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 5) == 0), din,
          4'($urandom), 4'($urandom));
      checks++; if (stat_out !== exp_stat()) begin failures++; $display("FAIL rnd_stat i=%0d got=%h exp=%h", i, stat_out, exp_stat()); end
      checks++; if (stopped !== logic'(m_stopped != 0) || irq !== logic'(m_irq != 0)) begin failures++; $display("FAIL rnd_flags i=%0d got=st%b irq%b exp=st%0d irq%0d", i, stopped, irq, m_stopped, m_irq); end
      checks++; if (reset_n !== exp_reset_n() || coll_ch !== 2'(m_ch)) begin failures++; $display("FAIL rnd_out i=%0d got=rn%b ch%0d exp=rn%b ch%0d", i, reset_n, coll_ch, exp_reset_n(), m_ch); end
      checks++; if (stat_oe !== statrd) begin failures++; $display("FAIL rnd_oe i=%0d got=%b exp=%b", i, stat_oe, statrd); end
    end
    resetl = 1'b1; xreset_n = 1'b1; statrd = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stop();
    test_stopped_ignore();
    test_abort();
    test_resume_abort();
    test_saturate();
    test_reset_mid_abort();
    test_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
